// File: rtl/iram_controller.sv
// Instruction-RAM refill controller: on an instruction-cache miss it reads one aligned
// line from a fixed-latency synchronous instruction memory and streams the words back
// to the core, one per cycle, each marked by a word_ready pulse.
module iram_controller #(
    parameter int ADDR_W      = 32,
    parameter int WORD_W      = 32,
    parameter int LINE_WORDS  = 4,
    parameter int MEM_AW      = 10,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] iram_address,
    output logic [WORD_W-1:0] imem_word,
    output logic              word_ready,
    output logic              busy,
    output logic              addr_err,
    output logic              mem_re,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata
);

    // Beat index width; the line is aligned, so a word address is {line index, beat}.
    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        WAIT_CLR
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [MEM_AW-BEAT_W-1:0]   line_index;
    logic                       out_of_range;
    logic [BEAT_W-1:0]          issue_cnt;
    logic [BEAT_W-1:0]          ret_cnt;
    logic [MEM_LATENCY-1:0]     valid_pipe;
    logic [WORD_W-1:0]          last_word;
    logic                       capture;
    logic                       last_return;
    logic                       unused_addr_bits;

    // The byte offset within a line never matters: the whole line is always fetched.
    assign unused_addr_bits = ^iram_address[BEAT_W+1:0];

    assign capture     = (state == IDLE) && i_miss;
    assign word_ready  = valid_pipe[MEM_LATENCY-1];
    assign last_return = word_ready && (ret_cnt == LAST_BEAT);
    assign imem_word   = word_ready ? mem_rdata : last_word;

    // State register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the memory-side and status outputs driven from the state.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        addr_err  = 1'b0;
        case (state)
            IDLE: begin
                if (i_miss) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                busy     = 1'b1;
                mem_re   = 1'b1;
                mem_addr = {line_index, issue_cnt};
                addr_err = out_of_range && (issue_cnt == '0);
                if (issue_cnt == LAST_BEAT) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (last_return) begin
                    state_nxt = WAIT_CLR;
                end
            end
            WAIT_CLR: begin
                busy = 1'b1;
                if (!i_miss) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request capture: the line index is frozen at accept so later address changes are ignored.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            line_index   <= '0;
            out_of_range <= 1'b0;
            issue_cnt    <= '0;
        end else if (capture) begin
            line_index   <= iram_address[MEM_AW+1:BEAT_W+2];
            out_of_range <= |iram_address[ADDR_W-1:MEM_AW+2];
            issue_cnt    <= '0;
        end else if (mem_re) begin
            issue_cnt    <= issue_cnt + BEAT_W'(1);
        end
    end

    // Return path: one valid bit per read in flight, a returned-word count, and the held word.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            valid_pipe <= '0;
            ret_cnt    <= '0;
            last_word  <= '0;
        end else begin
            valid_pipe <= (valid_pipe << 1) | MEM_LATENCY'(mem_re);
            if (capture) begin
                ret_cnt <= '0;
            end else if (word_ready) begin
                ret_cnt <= ret_cnt + BEAT_W'(1);
            end
            if (word_ready) begin
                last_word <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_iram_controller.sv
// Self-checking bench for iram_controller: a table of refill requests with cycle-exact
// checks of the memory side, plus a scoreboard that checks every returned word.
module tb_iram_controller;

    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;
    localparam int LW     = 4;
    localparam int MEM_AW = 10;
    localparam int LAT    = 2;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              i_miss = 1'b0;
    logic [ADDR_W-1:0] iram_address = '0;
    logic [WORD_W-1:0] imem_word;
    logic              word_ready;
    logic              busy;
    logic              addr_err;
    logic              mem_re;
    logic [MEM_AW-1:0] mem_addr;
    logic [WORD_W-1:0] mem_rdata;

    logic [WORD_W-1:0] mem_model [1024];
    logic [WORD_W-1:0] rd_stage;
    logic [WORD_W-1:0] sb [$];
    logic [WORD_W-1:0] exp_hold = '0;
    logic              mon_en = 1'b0;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] addr;
        int          hold;
        int          drop_at;
        logic [9:0]  base;
        logic        err;
    } vec_t;

    vec_t vecs [8];

    iram_controller #(
        .ADDR_W(ADDR_W), .WORD_W(WORD_W), .LINE_WORDS(LW),
        .MEM_AW(MEM_AW), .MEM_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .i_miss(i_miss),
        .iram_address(iram_address),
        .imem_word(imem_word),
        .word_ready(word_ready),
        .busy(busy),
        .addr_err(addr_err),
        .mem_re(mem_re),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Two-cycle synchronous instruction memory; junk on the bus when no read was issued.
    always @(posedge clk) begin
        rd_stage  <= mem_re ? mem_model[mem_addr] : $urandom;
        mem_rdata <= rd_stage;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
        end
    endtask

    // Scoreboard: every word_ready pops the next expected word; otherwise the word must hold.
    always @(negedge clk) begin
        if (mon_en) begin
            if (word_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected word_ready", 32'(word_ready), 32'd0);
                end else begin
                    logic [WORD_W-1:0] exp_word;
                    exp_word = sb.pop_front();
                    checkOutput("returned word", imem_word, exp_word);
                    exp_hold = exp_word;
                end
            end else begin
                checkOutput("held word", imem_word, exp_hold);
            end
        end
    end

    // Raise a miss and queue the line the bench expects back.
    task automatic applyStimulus(input logic [31:0] addr, input logic [9:0] base);
        i_miss       = 1'b1;
        iram_address = addr;
        for (int i = 0; i < LW; i++) begin
            sb.push_back(mem_model[int'(base) + i]);
        end
    endtask

    // One complete refill with cycle-by-cycle checks; ends at a negedge with the DUT idle.
    task automatic runRefill(input vec_t v);
        applyStimulus(v.addr, v.base);
        for (int t = 1; t <= LW + LAT + 1; t++) begin
            @(negedge clk);
            checkOutput($sformatf("busy t%0d", t), 32'(busy), 32'd1);
            checkOutput($sformatf("mem_re t%0d", t), 32'(mem_re), 32'(t <= LW));
            if (t <= LW) begin
                checkOutput($sformatf("mem_addr t%0d", t), 32'(mem_addr),
                            32'(v.base) + 32'(t - 1));
            end else begin
                checkOutput($sformatf("mem_addr idle t%0d", t), 32'(mem_addr), 32'd0);
            end
            checkOutput($sformatf("addr_err t%0d", t), 32'(addr_err),
                        (t == 1) ? 32'(v.err) : 32'd0);
            checkOutput($sformatf("word_ready t%0d", t), 32'(word_ready),
                        32'((t >= LAT + 1) && (t <= LW + LAT)));
            if (t == v.drop_at) begin
                i_miss       = 1'b0;
                iram_address = 32'h0000_0100;
            end
        end
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            checkOutput("stale miss busy", 32'(busy), 32'd1);
            checkOutput("stale miss mem_re", 32'(mem_re), 32'd0);
        end
        i_miss = 1'b0;
        @(negedge clk);
        checkOutput("idle after drop", 32'(busy), 32'd0);
    endtask

    // Reset asserted partway into a refill: nothing may come back afterwards.
    task automatic resetMidRefill();
        applyStimulus(32'h0000_0080, 10'h020);
        @(negedge clk);
        @(negedge clk);
        #1;
        nrst     = 1'b0;
        i_miss   = 1'b0;
        sb.delete();
        exp_hold = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checkOutput("reset busy", 32'(busy), 32'd0);
            checkOutput("reset mem_re", 32'(mem_re), 32'd0);
            checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
            checkOutput("reset word", imem_word, 32'd0);
        end
        nrst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("post-reset word_ready", 32'(word_ready), 32'd0);
            checkOutput("post-reset busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        vec_t fresh;
        for (int i = 0; i < 1024; i++) begin
            mem_model[i] = $urandom;
        end
        vecs[0] = '{32'h0000_0048, 5, 0, 10'h010, 1'b0};
        vecs[1] = '{32'h0000_0048, 0, 2, 10'h010, 1'b0};
        vecs[2] = '{32'h0000_1004, 0, 0, 10'h000, 1'b1};
        vecs[3] = '{32'h0000_0000, 0, 0, 10'h000, 1'b0};
        vecs[4] = '{32'h0000_0040, 0, 0, 10'h010, 1'b0};
        vecs[5] = '{32'h0000_2FF0, 0, 0, 10'h3FC, 1'b1};
        vecs[6] = '{32'h1234_5678, 0, 0, 10'h19C, 1'b1};
        vecs[7] = '{32'h0000_0FFF, 0, 0, 10'h3FC, 1'b0};
        fresh   = '{32'h0000_0080, 0, 0, 10'h020, 1'b0};

        nrst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset word_ready", 32'(word_ready), 32'd0);
        checkOutput("reset mem_re", 32'(mem_re), 32'd0);
        checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("reset addr_err", 32'(addr_err), 32'd0);
        checkOutput("reset word", imem_word, 32'd0);
        mon_en = 1'b1;
        nrst   = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            runRefill(vecs[i]);
        end

        resetMidRefill();
        runRefill(fresh);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
